// File: rtl/glitch_decoder.sv
// Recovers the strobe from a glitchy counter that steps +2,+2,+2,-5 and tracks phase lock.
// Optional saturating violation counter enabled by GLITCH_DECODER_ERRCNT_EN.
module glitch_decoder (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output logic       strobe_rec,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HUNT   = 2'd1;
  localparam logic [1:0] S_TRACK  = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  localparam logic [1:0] C_UP   = 2'd0;
  localparam logic [1:0] C_DOWN = 2'd1;
  localparam logic [1:0] C_BAD  = 2'd2;

  function automatic logic [1:0] classify(input logic [7:0] delta);
    case (delta)
      8'h02:   classify = C_UP;
      8'hFB:   classify = C_DOWN;
      default: classify = C_BAD;
    endcase
  endfunction

  logic [1:0] r_state;
  logic [1:0] r_ph;
  logic [7:0] r_prev;
  logic       r_strobe;
  logic       r_locked;
  logic       r_err;

  logic [7:0] w_delta;
  logic [1:0] w_cls;
  logic       w_up;
  logic       w_down;
  logic       w_exp_ok;
  logic [1:0] w_state_nxt;
  logic [1:0] w_ph_nxt;
  logic       w_err_nxt;
  logic       w_strobe_nxt;

  assign w_delta = sample - r_prev;
  assign w_cls   = classify(w_delta);
  assign w_up    = (w_cls == C_UP);
  assign w_down  = (w_cls == C_DOWN);

  always_comb begin
    w_state_nxt  = r_state;
    w_ph_nxt     = r_ph;
    w_err_nxt    = 1'b0;
    w_strobe_nxt = 1'b0;
    w_exp_ok     = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_HUNT;
      S_HUNT: begin
        w_strobe_nxt = w_down;
        if (w_down) begin
          w_state_nxt = S_TRACK;
          w_ph_nxt    = 2'd0;
        end else if (!w_up) begin
          w_err_nxt = 1'b1;
        end
      end
      default: begin
        w_strobe_nxt = w_down;
        w_exp_ok     = (r_ph == 2'd3) ? w_down : w_up;
        if (w_exp_ok) begin
          // ph==3 wraps to 0 on the expected DOWN
          w_ph_nxt = r_ph + 2'd1;
          if (w_down && (r_state == S_TRACK))
            w_state_nxt = S_LOCKED;
        end else begin
          w_err_nxt   = 1'b1;
          w_ph_nxt    = 2'd0;
          w_state_nxt = w_down ? S_TRACK : S_HUNT;
        end
      end
    endcase
  end

  // Register stage: state and outputs advance only on an accepted sample
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ph     <= 2'd0;
      r_prev   <= 8'd0;
      r_strobe <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else if (sample_valid) begin
      r_state  <= w_state_nxt;
      r_ph     <= w_ph_nxt;
      r_prev   <= sample;
      r_strobe <= w_strobe_nxt;
      r_locked <= (w_state_nxt == S_LOCKED);
      r_err    <= w_err_nxt;
    end else begin
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
    end
  end

  assign strobe_rec = r_strobe;
  assign locked     = r_locked;
  assign err        = r_err;

`ifdef GLITCH_DECODER_ERRCNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] r_err_count;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      r_err_count <= 8'd0;
    else if (sample_valid && w_err_nxt)
      r_err_count <= sat_inc(r_err_count);
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

endmodule
